// File: rtl/demux_pkg.sv
// Shared definitions for the stream demultiplexer: channel state encoding
// and the selector-width helper.
package demux_pkg;

  // Per-channel occupancy: EMPTY has no word, FULL holds one word for the consumer.
  typedef enum logic {
    CH_EMPTY = 1'b0,
    CH_FULL  = 1'b1
  } ch_state_e;

  // Selector width for n channels; never below 1 so a port always exists.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage : demux_pkg

// File: rtl/demux_slot.sv
// One output channel of the demultiplexer: a one-entry holding register with
// a two-state occupancy FSM and valid/ready handshake toward the consumer.
//
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   load      - write d into the slot this cycle (only issued while free)
//   d         - incoming payload
//   ready     - consumer accepts the held word
//   valid     - slot holds a word (registered)
//   q         - held word (registered, changes only on load)
//   free      - slot can take a word this cycle (EMPTY, or draining now)
module demux_slot
  import demux_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] q,
  output logic              free
);

  ch_state_e state_q;
  ch_state_e state_d;

  // Next-state: load always leaves the slot FULL; drain without load empties it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CH_EMPTY: if (load) state_d = CH_FULL;
      CH_FULL:  if (!load && ready) state_d = CH_EMPTY;
    endcase
  end

  // A FULL slot whose consumer is accepting can be refilled in the same cycle.
  assign free = (state_q == CH_EMPTY) || ready;

  // State, valid and data registers; valid mirrors the registered state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CH_EMPTY;
      valid   <= 1'b0;
      q       <= '0;
    end else begin
      state_q <= state_d;
      valid   <= (state_d == CH_FULL);
      if (load) q <= d;
    end
  end

endmodule : demux_slot

// File: rtl/demux_stream_nch.sv
// Registered 1-to-N stream demultiplexer with valid/ready on every port.
// A word is steered to the channel chosen by in_sel, or copied to all
// channels when in_bcast is set. Each channel buffers one word.
//
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   in_valid   - producer offers a word
//   in_ready   - word accepted this cycle (combinational, independent of in_valid)
//   in_data    - payload
//   in_sel     - target channel index
//   in_bcast   - send to every channel; in_sel ignored
//   out_valid  - per-channel word available
//   out_ready  - per-channel consumer accept
//   out_data   - channel k at bits [k*DATA_W +: DATA_W]
//   err_sel    - sticky: an out-of-range in_sel was accepted
module demux_stream_nch
  import demux_pkg::*;
#(
  parameter  int unsigned DATA_W = 8,
  parameter  int unsigned N_CH   = 4,
  localparam int unsigned SEL_W  = sel_width(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic                   in_bcast,
  output logic [N_CH-1:0]        out_valid,
  input  logic [N_CH-1:0]        out_ready,
  output logic [N_CH*DATA_W-1:0] out_data,
  output logic                   err_sel
);

  logic [N_CH-1:0] sel_oh;
  logic [N_CH-1:0] free;
  logic [N_CH-1:0] load;
  logic            in_range;
  logic            xfer;

  // Selector decode; an index >= N_CH matches no channel.
  always_comb begin
    sel_oh = '0;
    for (int k = 0; k < int'(N_CH); k++) begin
      sel_oh[k] = (in_sel == SEL_W'(k));
    end
  end

  assign in_range = |sel_oh;

  // Broadcast needs every channel free at once; out-of-range words are
  // always accepted so they can be dropped without stalling the producer.
  always_comb begin
    if (in_bcast)      in_ready = &free;
    else if (in_range) in_ready = |(sel_oh & free);
    else               in_ready = 1'b1;
  end

  // Nothing is recorded while reset is asserted.
  assign xfer = in_valid && in_ready && !rst;
  assign load = {N_CH{xfer}} & ({N_CH{in_bcast}} | sel_oh);

  // Channel slots.
  for (genvar k = 0; k < int'(N_CH); k++) begin : g_slot
    demux_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk   (clk),
      .rst   (rst),
      .load  (load[k]),
      .d     (in_data),
      .ready (out_ready[k]),
      .valid (out_valid[k]),
      .q     (out_data[k*DATA_W +: DATA_W]),
      .free  (free[k])
    );
  end

  // Sticky out-of-range flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst)                                 err_sel <= 1'b0;
    else if (xfer && !in_bcast && !in_range) err_sel <= 1'b1;
  end

endmodule : demux_stream_nch

// File: tb/tb_demux_stream_nch.sv
// Directed bench for demux_stream_nch: a vector table on a 4-channel instance
// plus a hand sequence on a 3-channel instance for out-of-range selectors.
module tb_demux_stream_nch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4-channel instance
  logic        rst, in_valid, in_ready, in_bcast, err_sel;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_valid, out_ready;
  logic [31:0] out_data;

  demux_stream_nch #(.DATA_W(8), .N_CH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .err_sel(err_sel)
  );

  // 3-channel instance (SEL_W = 2, index 3 is out of range)
  logic        rst3, in_valid3, in_ready3, in_bcast3, err_sel3;
  logic [7:0]  in_data3;
  logic [1:0]  in_sel3;
  logic [2:0]  out_valid3, out_ready3;
  logic [23:0] out_data3;

  demux_stream_nch #(.DATA_W(8), .N_CH(3)) dut3 (
    .clk(clk), .rst(rst3), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_data(in_data3), .in_sel(in_sel3), .in_bcast(in_bcast3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
    .err_sel(err_sel3)
  );

  typedef struct {
    logic        rst;
    logic        vld;
    logic [1:0]  sel;
    logic        bc;
    logic [7:0]  din;
    logic [3:0]  ordy;
    logic        e_rdy;
    logic [3:0]  e_ov;
    logic [31:0] e_od;
    logic        e_err;
  } vec_t;

  vec_t vq[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic v, input logic [1:0] s, input logic b,
                     input logic [7:0] d, input logic [3:0] o, input logic er,
                     input logic [3:0] eov, input logic [31:0] eod);
    vec_t t;
    t.rst = r; t.vld = v; t.sel = s; t.bc = b; t.din = d; t.ordy = o;
    t.e_rdy = er; t.e_ov = eov; t.e_od = eod; t.e_err = 1'b0;
    vq.push_back(t);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = '0; in_bcast = 1'b0; out_ready = '0;
    rst3 = 1'b1; in_valid3 = 1'b0; in_data3 = '0; in_sel3 = '0; in_bcast3 = 1'b0; out_ready3 = '0;

    //   rst vld sel bc  din    ordy     rdy  ov       od
    // reset with a word offered: nothing is captured
    add(1, 1, 0, 0, 8'h11, 4'b1111, 1, 4'b0000, 32'h0000_0000);
    add(1, 1, 1, 0, 8'h12, 4'b1111, 1, 4'b0000, 32'h0000_0000);
    add(0, 0, 0, 0, 8'h00, 4'b1111, 1, 4'b0000, 32'h0000_0000);
    // unicast sweep, consumers always ready
    add(0, 1, 0, 0, 8'hA0, 4'b1111, 1, 4'b0001, 32'h0000_00A0);
    add(0, 1, 1, 0, 8'hA1, 4'b1111, 1, 4'b0010, 32'h0000_A1A0);
    add(0, 1, 2, 0, 8'hA2, 4'b1111, 1, 4'b0100, 32'h00A2_A1A0);
    add(0, 1, 3, 0, 8'hA3, 4'b1111, 1, 4'b1000, 32'hA3A2_A1A0);
    add(0, 0, 3, 0, 8'h00, 4'b1111, 1, 4'b0000, 32'hA3A2_A1A0);
    // back-pressure on channel 2
    add(0, 1, 2, 0, 8'h55, 4'b1011, 1, 4'b0100, 32'hA355_A1A0);
    add(0, 1, 2, 0, 8'h66, 4'b1011, 0, 4'b0100, 32'hA355_A1A0);
    add(0, 1, 2, 0, 8'h66, 4'b1011, 0, 4'b0100, 32'hA355_A1A0);
    add(0, 1, 2, 0, 8'h66, 4'b1111, 1, 4'b0100, 32'hA366_A1A0);
    add(0, 0, 2, 0, 8'h00, 4'b1111, 1, 4'b0000, 32'hA366_A1A0);
    // broadcast blocked by channel 1, then released
    add(0, 1, 1, 0, 8'h99, 4'b1101, 1, 4'b0010, 32'hA366_99A0);
    add(0, 1, 0, 1, 8'h3C, 4'b1101, 0, 4'b0010, 32'hA366_99A0);
    add(0, 1, 0, 1, 8'h3C, 4'b1111, 1, 4'b1111, 32'h3C3C_3C3C);
    // hold everything; in_ready low with in_valid low
    add(0, 0, 0, 0, 8'h00, 4'b0000, 0, 4'b1111, 32'h3C3C_3C3C);
    // drain channel 3 only, leaving three FULL
    add(0, 0, 0, 0, 8'h00, 4'b1000, 0, 4'b0111, 32'h3C3C_3C3C);
    // mid-operation reset, then a normal unicast
    add(1, 0, 3, 0, 8'h00, 4'b0000, 1, 4'b0000, 32'h0000_0000);
    add(0, 1, 0, 0, 8'h42, 4'b1111, 1, 4'b0001, 32'h0000_0042);
    add(0, 0, 0, 0, 8'h00, 4'b1111, 1, 4'b0000, 32'h0000_0042);

    @(posedge clk); #1;
    foreach (vq[i]) begin
      rst = vq[i].rst; in_valid = vq[i].vld; in_sel = vq[i].sel;
      in_bcast = vq[i].bc; in_data = vq[i].din; out_ready = vq[i].ordy;
      #1;
      chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vq[i].e_rdy));
      @(posedge clk); #1;
      chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vq[i].e_ov));
      chk($sformatf("v%0d out_data", i), out_data, vq[i].e_od);
      chk($sformatf("v%0d err_sel", i), 32'(err_sel), 32'(vq[i].e_err));
    end

    // 3-channel instance: boundary index 2, then out-of-range index 3
    rst3 = 1'b1; out_ready3 = 3'b111;
    @(posedge clk); #1;
    rst3 = 1'b0;
    chk("n3 reset err_sel", 32'(err_sel3), 32'd0);
    chk("n3 reset out_valid", 32'(out_valid3), 32'd0);
    in_valid3 = 1'b1; in_sel3 = 2'd2; in_data3 = 8'h2C;
    #1 chk("n3 sel2 in_ready", 32'(in_ready3), 32'd1);
    @(posedge clk); #1;
    chk("n3 sel2 out_valid", 32'(out_valid3), 32'b100);
    chk("n3 sel2 out_data", 32'(out_data3), 32'h2C_0000);
    in_sel3 = 2'd3; in_data3 = 8'h77;
    #1 chk("n3 oor in_ready", 32'(in_ready3), 32'd1);
    chk("n3 oor err before edge", 32'(err_sel3), 32'd0);
    @(posedge clk); #1;
    chk("n3 oor out_valid", 32'(out_valid3), 32'd0);
    chk("n3 oor out_data", 32'(out_data3), 32'h2C_0000);
    chk("n3 oor err_sel", 32'(err_sel3), 32'd1);
    in_sel3 = 2'd1; in_data3 = 8'h21;
    @(posedge clk); #1;
    in_valid3 = 1'b0;
    chk("n3 sel1 out_valid", 32'(out_valid3), 32'b010);
    chk("n3 sel1 out_data", 32'(out_data3), 32'h2C_2100);
    repeat (3) @(posedge clk);
    #1 chk("n3 err sticky", 32'(err_sel3), 32'd1);
    rst3 = 1'b1;
    @(posedge clk); #1;
    rst3 = 1'b0;
    chk("n3 err cleared", 32'(err_sel3), 32'd0);
    chk("n3 data cleared", 32'(out_data3), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_demux_stream_nch
